// File: rtl/mem_march_pkg.sv
// Shared types and March C- element table for the memory self-test controller.
package mem_march_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  typedef enum logic [1:0] {W0, W1, R0, R1} op_t;

  localparam int unsigned NUM_ELEM = 6;
  localparam int unsigned MAX_OPS  = 2;

  // Bit e set: element e walks addresses from the top down.
  localparam logic [NUM_ELEM-1:0] ELEM_DOWN = 6'b011000;

  localparam logic [1:0] ELEM_NOPS [NUM_ELEM] = '{2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1};

  localparam op_t ELEM_OPS [NUM_ELEM][MAX_OPS] = '{
    '{W0, W0},
    '{R0, W1},
    '{R1, W0},
    '{R0, W1},
    '{R1, W0},
    '{R0, R0}
  };

  function automatic logic op_is_write(op_t op);
    return (op == W0) || (op == W1);
  endfunction

  function automatic logic op_is_one(op_t op);
    return (op == W1) || (op == R1);
  endfunction

endpackage

// File: rtl/mem_addr_counter.sv
// Up/down address counter with load-zero/load-max, enable and terminal-count flag.
module mem_addr_counter #(
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_zero,
  input  logic              ld_max,
  input  logic              en,
  input  logic              down,
  output logic [ADDR_W-1:0] count,
  output logic              tc
);

  logic [ADDR_W-1:0] count_n;

  always_comb begin
    count_n = count;
    if (ld_zero)
      count_n = '0;
    else if (ld_max)
      count_n = '1;
    else if (en)
      count_n = down ? count - ADDR_W'(1) : count + ADDR_W'(1);
  end

  assign tc = down ? (count == '0) : (count == '1);

  always_ff @(posedge clk) begin
    if (!rst)
      count <= '0;
    else
      count <= count_n;
  end

endmodule

// File: rtl/mem_march_ctrl.sv
// March C- self-test controller driving a single-port synchronous RAM.
// Optional second checkerboard-background pass: define MEM_MARCH_CHECKERBOARD_EN.
module mem_march_ctrl
  import mem_march_pkg::*;
#(
  parameter int unsigned ADDR_W       = 4,
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned STOP_ON_FAIL = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [3:0]        fail_elem,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata
);

`ifdef MEM_MARCH_CHECKERBOARD_EN
  localparam logic LAST_PASS = 1'b1;
`else
  localparam logic LAST_PASS = 1'b0;
`endif

  // Background is 0x55.. on even addresses and 0xAA.. on odd ones in pass 1.
  function automatic logic [DATA_W-1:0] datum(op_t op, logic pass, logic odd);
    logic [DATA_W-1:0] bg;
    for (int unsigned i = 0; i < DATA_W; i++)
      bg[i] = pass & (i[0] == odd);
    return op_is_one(op) ? ~bg : bg;
  endfunction

  state_t            state_q, state_n;
  logic [2:0]        elem_q, elem_n;
  logic              opi_q, opi_n;
  logic              ph_q, ph_n;
  logic              pass_q, pass_n;
  logic              ld_zero, ld_max, cnt_en, tc;
  logic              mismatch, nxt_odd;
  op_t               cur_op, nxt_op;
  logic [DATA_W-1:0] exp_data;

  mem_addr_counter #(.ADDR_W(ADDR_W)) u_cnt (
    .clk     (clk),
    .rst     (rst),
    .ld_zero (ld_zero),
    .ld_max  (ld_max),
    .en      (cnt_en),
    .down    (ELEM_DOWN[elem_q]),
    .count   (mem_addr),
    .tc      (tc)
  );

  always_comb begin
    state_n  = state_q;
    elem_n   = elem_q;
    opi_n    = opi_q;
    ph_n     = ph_q;
    pass_n   = pass_q;
    ld_zero  = 1'b0;
    ld_max   = 1'b0;
    cnt_en   = 1'b0;
    mismatch = 1'b0;
    cur_op   = ELEM_OPS[elem_q][opi_q];
    exp_data = datum(cur_op, pass_q, mem_addr[0]);

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_n = RUN;
          elem_n  = '0;
          opi_n   = 1'b0;
          ph_n    = 1'b0;
          pass_n  = 1'b0;
          ld_zero = 1'b1;
        end
      end
      RUN: begin
        if (!op_is_write(cur_op) && !ph_q) begin
          ph_n = 1'b1;
        end else begin
          mismatch = !op_is_write(cur_op) && (mem_rdata != exp_data);
          ph_n     = 1'b0;
          if ((STOP_ON_FAIL != 0) && mismatch) begin
            state_n = DONE;
          end else if ({1'b0, opi_q} != ELEM_NOPS[elem_q] - 2'd1) begin
            opi_n = opi_q + 1'b1;
          end else begin
            opi_n = 1'b0;
            if (!tc) begin
              cnt_en = 1'b1;
            end else if (elem_q != 3'(NUM_ELEM - 1)) begin
              elem_n = elem_q + 3'd1;
              if (ELEM_DOWN[elem_n])
                ld_max = 1'b1;
              else
                ld_zero = 1'b1;
            end else if (pass_q != LAST_PASS) begin
              pass_n  = 1'b1;
              elem_n  = '0;
              ld_zero = 1'b1;
            end else begin
              state_n = DONE;
            end
          end
        end
      end
      default: state_n = IDLE;
    endcase

    // Outputs are registered from the upcoming op, so predict the next address parity.
    nxt_op  = ELEM_OPS[elem_n][opi_n];
    nxt_odd = ld_zero ? 1'b0 : ld_max ? 1'b1 : cnt_en ? ~mem_addr[0] : mem_addr[0];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      elem_q    <= '0;
      opi_q     <= 1'b0;
      ph_q      <= 1'b0;
      pass_q    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      mem_we    <= 1'b0;
      mem_re    <= 1'b0;
      mem_wdata <= '0;
      fail      <= 1'b0;
      fail_addr <= '0;
      fail_elem <= '0;
    end else begin
      state_q   <= state_n;
      elem_q    <= elem_n;
      opi_q     <= opi_n;
      ph_q      <= ph_n;
      pass_q    <= pass_n;
      busy      <= (state_n == RUN);
      done      <= (state_n == DONE);
      mem_we    <= (state_n == RUN) && op_is_write(nxt_op);
      mem_re    <= (state_n == RUN) && !op_is_write(nxt_op) && !ph_n;
      mem_wdata <= ((state_n == RUN) && op_is_write(nxt_op)) ? datum(nxt_op, pass_n, nxt_odd) : '0;
      if ((state_q != RUN) && start) begin
        fail      <= 1'b0;
        fail_addr <= '0;
        fail_elem <= '0;
      end else if (mismatch && !fail) begin
        fail      <= 1'b1;
        fail_addr <= mem_addr;
        fail_elem <= {pass_q, elem_q};
      end
    end
  end

endmodule
